grf_scoreboard: RTL and testbench

- General register file (32 x 32-bit MIPS GPRs) that consumes the write-back address/data produced by the write-back mux and supplies Rs/Rt operands to decode.
- Adds write-through bypass and a per-register pending-write scoreboard so the pipelined core can detect read-after-write hazards and stall.
- Sits between the write-back selection stage (write port) and the decode/operand stage (read ports, busy/stall outputs).

---
 rtl/grf_scoreboard_pkg.sv | 7 +
 rtl/grf_scoreboard_pend_cnt.sv | 29 ++
 rtl/grf_scoreboard.sv | 108 ++++++++++
 tb/tb_grf_scoreboard.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/grf_scoreboard_pkg.sv
// Shared constants for the GPR file and its pending-write scoreboard.
package grf_scoreboard_pkg;
    localparam int NREG = 32;
    localparam int DEF_CNT_W = 2;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA = 5'd31;
endpackage

// File: rtl/grf_scoreboard_pend_cnt.sv
// One per-register in-flight write counter; it never wraps in either direction.
module grf_pend_cnt
    import grf_scoreboard_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             full
);

    assign zero = (cnt == '0);
    assign full = &cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/grf_scoreboard.sv
// 32x32 GPR file with write-through bypass and per-register pending-write
// scoreboard for RAW hazard detection.
module grf_scoreboard
    import grf_scoreboard_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ReadAddr1,
    input  logic [4:0]  ReadAddr2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    input  logic        WE,
    input  logic [4:0]  WriteAddr,
    input  logic [31:0] RegData,
    input  logic        IssueValid,
    input  logic [4:0]  IssueAddr,
    output logic        IssueReady,
    output logic        Busy1,
    output logic        Busy2,
    output logic        Stall,
    output logic        Underflow
);

    logic [31:0] regs [NREG];

    logic [NREG-1:0][CNT_W-1:0] pend;
    logic [NREG-1:0] zero;
    logic [NREG-1:0] full;
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;
    logic [NREG-1:0] to_zero;

    logic wr_en;

    assign wr_en = WE && (WriteAddr != REG_ZERO);

    // $0 is never tracked: empty, never full, never retiring.
    assign pend[0]    = '0;
    assign zero[0]    = 1'b1;
    assign full[0]    = 1'b0;
    assign inc[0]     = 1'b0;
    assign dec[0]     = 1'b0;
    assign to_zero[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        assign inc[r] = IssueValid && IssueReady
                        && (IssueAddr == 5'(r));
        assign dec[r] = WE && (WriteAddr == 5'(r)) && !zero[r];
        assign to_zero[r] = dec[r] && !inc[r]
                            && (pend[r] == CNT_W'(1));

        grf_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc[r]),
            .dec   (dec[r]),
            .cnt   (pend[r]),
            .zero  (zero[r]),
            .full  (full[r])
        );
    end

    assign IssueReady = (IssueAddr == REG_ZERO) || !full[IssueAddr];

    // A retire that empties the counter also bypasses the data, so no stall.
    assign Busy1 = !zero[ReadAddr1] && !to_zero[ReadAddr1];
    assign Busy2 = !zero[ReadAddr2] && !to_zero[ReadAddr2];
    assign Stall = Busy1 || Busy2 || (IssueValid && !IssueReady);

    always_comb begin
        ReadData1 = regs[ReadAddr1];
        if (ReadAddr1 == REG_ZERO) begin
            ReadData1 = '0;
        end else if (wr_en && (WriteAddr == ReadAddr1)) begin
            ReadData1 = RegData;
        end
    end

    always_comb begin
        ReadData2 = regs[ReadAddr2];
        if (ReadAddr2 == REG_ZERO) begin
            ReadData2 = '0;
        end else if (wr_en && (WriteAddr == ReadAddr2)) begin
            ReadData2 = RegData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[WriteAddr] <= RegData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Underflow <= 1'b0;
        end else if (wr_en && zero[WriteAddr]) begin
            Underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed and random checks of grf_scoreboard against an array-based model.
module tb_grf_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ReadAddr1, ReadAddr2, WriteAddr, IssueAddr;
    logic [31:0] ReadData1, ReadData2, RegData;
    logic        WE, IssueValid, IssueReady;
    logic        Busy1, Busy2, Stall, Underflow;

    int n_chk = 0;
    int n_fail = 0;

    int          m_pend [32];
    logic [31:0] m_regs [32];
    bit          m_uf;

    localparam int MAXP = 3;

    always #5 clk = ~clk;

    grf_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .ReadAddr1  (ReadAddr1),
        .ReadAddr2  (ReadAddr2),
        .ReadData1  (ReadData1),
        .ReadData2  (ReadData2),
        .WE         (WE),
        .WriteAddr  (WriteAddr),
        .RegData    (RegData),
        .IssueValid (IssueValid),
        .IssueAddr  (IssueAddr),
        .IssueReady (IssueReady),
        .Busy1      (Busy1),
        .Busy2      (Busy2),
        .Stall      (Stall),
        .Underflow  (Underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_pend[i] = 0;
            m_regs[i] = '0;
        end
        m_uf = 1'b0;
    endtask

    function automatic bit m_ready(input logic [4:0] a);
        return (a == 0) || (m_pend[a] < MAXP);
    endfunction

    function automatic int m_next(input logic [4:0] r);
        int n;
        n = m_pend[r];
        if (r == 0) return 0;
        if (IssueValid && m_ready(IssueAddr) && IssueAddr == r) n++;
        if (WE && WriteAddr == r && m_pend[r] > 0) n--;
        return n;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return '0;
        if (WE && WriteAddr == a) return RegData;
        return m_regs[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        return (a != 0) && (m_pend[a] > 0) && (m_next(a) != 0);
    endfunction

    // Drive one cycle, compare every output mid-cycle, then commit the model.
    task automatic step(input bit iv, input logic [4:0] ia,
                        input bit we, input logic [4:0] wa,
                        input logic [31:0] d,
                        input logic [4:0] r1, input logic [4:0] r2);
        int nxt [32];
        bit b1, b2, rdy;
        IssueValid = iv; IssueAddr = ia;
        WE = we; WriteAddr = wa; RegData = d;
        ReadAddr1 = r1; ReadAddr2 = r2;
        #3;
        b1 = m_busy(r1);
        b2 = m_busy(r2);
        rdy = m_ready(ia);
        chk("rd1", ReadData1, m_read(r1));
        chk("rd2", ReadData2, m_read(r2));
        chk("ready", 32'(IssueReady), 32'(rdy));
        chk("busy1", 32'(Busy1), 32'(b1));
        chk("busy2", 32'(Busy2), 32'(b2));
        chk("stall", 32'(Stall), 32'(b1 | b2 | (iv & ~rdy)));
        chk("uflow", 32'(Underflow), 32'(m_uf));
        for (int i = 0; i < 32; i++) nxt[i] = m_next(5'(i));
        if (we && wa != 0) begin
            if (m_pend[wa] == 0) m_uf = 1'b1;
            m_regs[wa] = d;
        end
        for (int i = 0; i < 32; i++) m_pend[i] = nxt[i];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        step(0, 0, 0, 0, 32'h0, r1, r2);
    endtask

    initial begin
        reset = 1'b0;
        IssueValid = 0; IssueAddr = 0; WE = 0; WriteAddr = 0;
        RegData = 0; ReadAddr1 = 0; ReadAddr2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state
        idle(5'd8, 5'd31);
        chk("rst_rd", ReadData1, 32'h0);
        chk("rst_rdy", 32'(IssueReady), 32'h1);

        // Write with same-cycle bypass, then readback
        step(0, 0, 1, 5'd8, 32'h1234_5678, 5'd8, 5'd0);
        idle(5'd8, 5'd8);
        chk("wr8", ReadData1, 32'h1234_5678);
        // Writes to $0 are dropped
        step(0, 0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk("r0", ReadData1, 32'h0);

        // RAW: reserve 9, see busy, retire with bypass
        step(1, 5'd9, 0, 0, 0, 5'd0, 5'd0);
        idle(5'd0, 5'd9);
        chk("raw_busy", 32'(Busy2), 32'h1);
        chk("raw_stall", 32'(Stall), 32'h1);
        step(0, 0, 1, 5'd9, 32'hA5, 5'd0, 5'd9);
        idle(5'd0, 5'd9);
        chk("raw_data", ReadData2, 32'hA5);
        chk("raw_clear", 32'(Busy2), 32'h0);

        // Saturation of reg 3
        repeat (3) step(1, 5'd3, 0, 0, 0, 5'd3, 5'd0);
        step(1, 5'd3, 0, 0, 0, 5'd3, 5'd0);
        chk("sat_rdy", 32'(IssueReady), 32'h0);
        chk("sat_stall", 32'(Stall), 32'h1);
        step(0, 0, 1, 5'd3, 32'h31, 5'd3, 5'd0);
        step(0, 0, 1, 5'd3, 32'h32, 5'd3, 5'd0);
        step(0, 0, 1, 5'd3, 32'h33, 5'd3, 5'd0);
        idle(5'd3, 5'd0);
        chk("sat_free", 32'(Busy1), 32'h0);
        chk("sat_data", ReadData1, 32'h33);

        // Issue and retire of reg 5 together
        step(1, 5'd5, 0, 0, 0, 5'd0, 5'd0);
        step(1, 5'd5, 1, 5'd5, 32'h55, 5'd5, 5'd0);
        idle(5'd5, 5'd0);
        chk("sim_busy", 32'(Busy1), 32'h1);
        chk("sim_data", ReadData1, 32'h55);
        step(0, 0, 1, 5'd5, 32'h56, 5'd5, 5'd0);

        // Untracked write, then asynchronous reset between edges
        step(0, 0, 1, 5'd7, 32'h77, 5'd7, 5'd0);
        step(1, 5'd7, 0, 0, 0, 5'd7, 5'd0);
        chk("uf_set", 32'(Underflow), 32'h1);
        chk("uf_data", ReadData1, 32'h77);
        ReadAddr1 = 5'd7; IssueValid = 0; WE = 0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("ar_uf", 32'(Underflow), 32'h0);
        chk("ar_data", ReadData1, 32'h0);
        chk("ar_busy", 32'(Busy1), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        idle(5'd7, 5'd8);

        // Random traffic on a narrow address window to provoke hazards
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 1), 5'($urandom_range(0, 6)),
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 6)),
                 $urandom, 5'($urandom_range(0, 6)),
                 5'($urandom_range(0, 6)));
            if (k == 300) begin
                #2 reset = 1'b0;
                model_reset();
                @(posedge clk);
                #1 reset = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
